// File: rtl/peripheral_operand_loader.sv
// Operand-entry and result-viewing front end for the board-level ALU wrapper.
// Debounced buttons load operands chunk by chunk, then step through the result.
module peripheral_operand_loader #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IN_W    = 8,
  parameter int unsigned NUM_OPS = 2,
  localparam int unsigned CHUNKS = DATA_W / IN_W,
  localparam int unsigned CW     = $clog2(CHUNKS),
  localparam int unsigned OW     = $clog2(NUM_OPS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enter,
  input  logic                      back,
  input  logic                      loaddata,
  input  logic [IN_W-1:0]           inputdata,
  input  logic [DATA_W-1:0]         dataR,
  input  logic                      ack,
  output logic [NUM_OPS*DATA_W-1:0] operands,
  output logic                      inputdata_ready,
  output logic [OW-1:0]             disp_op,
  output logic [CW-1:0]             disp_chunk,
  output logic [IN_W-1:0]           disp_data
);

  localparam int unsigned OPS_W = NUM_OPS * DATA_W;

  typedef enum logic [1:0] {ST_LOAD, ST_READY, ST_VIEW} state_t;

  state_t             state, state_n;
  logic [OW-1:0]      op_idx_n;
  logic [CW-1:0]      chunk_idx_n;
  logic [OPS_W-1:0]   operands_n;
  logic               ready_n;
  logic [31:0]        wr_base;

  // Sync + edge flops preset to 1 so a button held through reset never fires
  logic [2:0] en_sync, bk_sync;
  logic       en_rise, bk_rise, en_pulse, bk_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_sync <= 3'b111;
      bk_sync <= 3'b111;
    end else begin
      en_sync <= {en_sync[1:0], enter};
      bk_sync <= {bk_sync[1:0], back};
    end
  end

  assign en_rise  = en_sync[1] & ~en_sync[2];
  assign bk_rise  = bk_sync[1] & ~bk_sync[2];
  assign en_pulse = en_rise & ~bk_rise;
  assign bk_pulse = bk_rise & ~en_rise;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_LOAD;
      disp_op         <= '0;
      disp_chunk      <= '0;
      operands        <= '0;
      inputdata_ready <= 1'b0;
    end else begin
      state           <= state_n;
      disp_op         <= op_idx_n;
      disp_chunk      <= chunk_idx_n;
      operands        <= operands_n;
      inputdata_ready <= ready_n;
    end
  end

  // Next-state, pointer and operand-write logic
  always_comb begin
    state_n     = state;
    op_idx_n    = disp_op;
    chunk_idx_n = disp_chunk;
    operands_n  = operands;
    ready_n     = inputdata_ready;
    wr_base     = 32'(disp_op) * DATA_W + 32'(disp_chunk) * IN_W;

    case (state)
      ST_LOAD: begin
        if (loaddata && en_pulse) begin
          operands_n[wr_base +: IN_W] = inputdata;
          if (disp_chunk == CW'(CHUNKS - 1)) begin
            chunk_idx_n = '0;
            if (disp_op == OW'(NUM_OPS - 1)) begin
              state_n  = ST_READY;
              ready_n  = 1'b1;
              op_idx_n = OW'(NUM_OPS);
            end else begin
              op_idx_n = disp_op + OW'(1);
            end
          end else begin
            chunk_idx_n = disp_chunk + CW'(1);
          end
        end else if (loaddata && bk_pulse) begin
          if (disp_chunk != '0) begin
            chunk_idx_n = disp_chunk - CW'(1);
          end else if (disp_op != '0) begin
            op_idx_n    = disp_op - OW'(1);
            chunk_idx_n = CW'(CHUNKS - 1);
          end
        end
      end

      ST_READY: begin
        if (ack) begin
          state_n = ST_VIEW;
          ready_n = 1'b0;
        end
      end

      ST_VIEW: begin
        if (loaddata) begin
          state_n     = ST_LOAD;
          op_idx_n    = '0;
          chunk_idx_n = '0;
        end else if (en_pulse) begin
          chunk_idx_n = (disp_chunk == CW'(CHUNKS - 1)) ? '0 : disp_chunk + CW'(1);
        end else if (bk_pulse) begin
          chunk_idx_n = (disp_chunk == '0) ? CW'(CHUNKS - 1) : disp_chunk - CW'(1);
        end
      end

      default: begin
        state_n = ST_LOAD;
      end
    endcase
  end

  // Live switch echo while loading, otherwise the selected result chunk
  always_comb begin
    disp_data = inputdata;
    if (state != ST_LOAD) begin
      disp_data = dataR[32'(disp_chunk) * IN_W +: IN_W];
    end
  end

endmodule

// File: doc/peripheral_operand_loader.md
Name: peripheral_operand_loader

Overview:
- Parametrised operand-entry and result-viewing front end for the board-level ALU wrapper.
- Assembles NUM_OPS operands of DATA_W bits from IN_W-bit switch chunks, one chunk per debounced enter press.
- Raises inputdata_ready, with an ack handshake, once all operands are loaded.
- Lets the user step forward or backward through dataR chunks, and exports digit/index codes for the 7-segment decoders.

Parameters:
- DATA_W, 32, operand and result width; must be a multiple of IN_W.
- IN_W, 8, switch/chunk width.
- NUM_OPS, 2, number of operands, 1..7; index NUM_OPS denotes R.
- Derived: CHUNKS = DATA_W/IN_W (must be at least 2); CW = clog2(CHUNKS); OW = clog2(NUM_OPS+1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enter  in  1  raw push-button level, asynchronous to clk
- back  in  1  raw push-button level, step-back request
- loaddata  in  1  1 = load mode, 0 = view mode
- inputdata  in  IN_W  switch value
- dataR  in  DATA_W  ALU result
- ack  in  1  consumer acknowledges inputdata_ready
- operands  out  NUM_OPS*DATA_W  packed operands; operand 0 in LSBs
- inputdata_ready  out  1  all operands loaded; held until ack
- disp_op  out  OW  operand index shown (NUM_OPS = R)
- disp_chunk  out  CW  chunk index shown
- disp_data  out  IN_W  chunk value for hex decoders

Behaviour:
- Reset (reset=0, takes effect immediately):
  - operands=0, inputdata_ready=0, disp_op=0, disp_chunk=0, state=LOAD.
  - Synchronizer and edge flops for enter/back reset to 1, so a button held through reset release never fires.
- Button conditioning:
  - Each button passes through a 2-flop synchronizer, then rising-edge detection, producing a 1-cycle pulse.
  - State updates on the 3rd rising clk edge after the button rises.
  - A held button produces exactly one pulse.
  - enter and back pulses in the same cycle: both ignored.
- FSM LOAD:
  - Pointer {op_idx, chunk_idx} is exported on disp_op/disp_chunk; disp_data = inputdata (live echo).
  - enter pulse with loaddata=1: operand[op_idx][chunk_idx*IN_W +: IN_W] <= inputdata, then the pointer advances. chunk_idx wraps CHUNKS-1 -> 0 and increments op_idx.
  - Write to the final chunk of operand NUM_OPS-1: go to READY; inputdata_ready=1 on that same edge; pointer set to {NUM_OPS, 0}.
  - back pulse: pointer decrements with no write; saturates at {0, 0}.
  - loaddata=0 in LOAD: pulses ignored, pointer frozen.
- FSM READY:
  - inputdata_ready=1; disp_op=NUM_OPS; disp_data = dataR chunk at disp_chunk.
  - ack=1 sampled at an edge: inputdata_ready=0 next cycle, go to VIEW.
  - Button pulses ignored.
- FSM VIEW:
  - disp_op=NUM_OPS; disp_data = dataR[disp_chunk*IN_W +: IN_W] (combinational from dataR).
  - enter pulse: disp_chunk+1, wrapping CHUNKS-1 -> 0.
  - back pulse: disp_chunk-1, wrapping 0 -> CHUNKS-1.
  - loaddata=1 sampled: go to LOAD with pointer {0, 0}. Operands are retained until overwritten.
- All registered outputs are glitch-free. disp_data is combinational from registered state, inputdata and dataR.
- Reset mid-operation: immediate clear. No write occurs from the pending synchronizer state after release.

Test Plan (defaults DATA_W=32, IN_W=8, NUM_OPS=2):
- Full load: release reset; press enter with 00, 00, 80, 3F, 7D, 86, BE, A1 -> operands = {A1BE867D, 3F800000}; inputdata_ready rises on the same edge as the 8th write; disp_op=2.
- Hold enter high for 10 cycles with inputdata=55 -> exactly one write at chunk 0; pointer = {0, 1}.
- Load 11, 22, 33; press back; load 44 -> operand 0 = xx442211 (chunk 2 overwritten, chunk 3 untouched); pointer = {0, 3}.
- Full load, ack pulse, dataR=C2820000, loaddata=0:
  - disp_data sequence is 00 (chunk 0), then after each enter 00, 82, C2, 00 (wrap).
  - back from chunk 0 -> chunk 3, disp_data = C2.
- Assert reset after 5 writes while enter is held, release with enter still held -> all outputs 0, no write until enter is released and pressed again.
- In VIEW set loaddata=1 -> LOAD, pointer {0, 0}, operands unchanged. Pulse enter and back on the same cycle -> no write, pointer unchanged.
